// File: rtl/quiz_pkg.sv
// Shared quiz constants: background colours, controller state encoding and
// the per-question expected switch answers.
package quiz_pkg;

    localparam logic [11:0] BG_IDLE = 12'h000;
    localparam logic [11:0] BG_ASK  = 12'h224;
    localparam logic [11:0] BG_OK   = 12'h0F0;
    localparam logic [11:0] BG_BAD  = 12'hF00;
    localparam logic [11:0] BG_DONE = 12'h00F;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASK      = 2'd1,
        ST_FEEDBACK = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Question 0 is the binary-conversion prompt, hence the binary literal.
    function automatic logic [7:0] expected_answer(input logic [3:0] idx);
        case (idx)
            4'd0:    expected_answer = 8'b1101_0011;
            4'd1:    expected_answer = 8'h2A;
            4'd2:    expected_answer = 8'h07;
            4'd3:    expected_answer = 8'hFF;
            default: expected_answer = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-clock frame pulse from the shared raster counters; immune to the pixel
// enable holding the counters at the origin for several clocks.
module frame_tick_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic       frame_tick
);

    logic origin_q;
    logic origin_prev_q;

    // NOTE: registers take <= so every flop samples the pre-edge value; a
    // blocking = here would let origin_prev_q see this cycle's origin_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            origin_q      <= 1'b0;
            origin_prev_q <= 1'b1;
        end else begin
            origin_q      <= (hCount == 10'd0) && (vCount == 10'd0);
            origin_prev_q <= origin_q;
        end
    end

    // Rising edge of the registered origin flag only.
    assign frame_tick = origin_q && !origin_prev_q;

endmodule

// File: rtl/prompt_sequencer.sv
// Quiz-flow controller: enables each prompt controller in turn, grades the
// switch answer, enforces a frame-based time limit and flashes feedback.
module prompt_sequencer
    import quiz_pkg::*;
#(
    parameter int NUM_Q        = 4,
    parameter int LIMIT_FRAMES = 600,
    parameter int FB_FRAMES    = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       hCount,
    input  logic [9:0]       vCount,
    input  logic             start,
    input  logic             submit,
    input  logic [7:0]       answer,
    output logic [NUM_Q-1:0] q_en,
    output logic [11:0]      background,
    output logic [3:0]       score,
    output logic [9:0]       time_left,
    output logic             done
);

    localparam int FBW = (FB_FRAMES > 1) ? $clog2(FB_FRAMES) : 1;

    localparam logic [NUM_Q-1:0] Q_FIRST = NUM_Q'(1);
    localparam logic [3:0]       Q_LAST  = 4'(NUM_Q - 1);
    localparam logic [FBW-1:0]   FB_LAST = FBW'(FB_FRAMES - 1);
    localparam logic [9:0]       LIMIT   = 10'(LIMIT_FRAMES);

    state_e           state_q;
    logic [3:0]       q_idx_q;
    logic [FBW-1:0]   fb_cnt_q;
    logic [NUM_Q-1:0] q_en_q;
    logic [11:0]      bg_q;
    logic [3:0]       score_q;
    logic [9:0]       time_left_q;
    logic             done_q;

    logic       frame_tick;
    logic       answer_ok;
    logic [9:0] time_left_d;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .hCount     (hCount),
        .vCount     (vCount),
        .frame_tick (frame_tick)
    );

    assign answer_ok   = (answer == expected_answer(q_idx_q));
    assign time_left_d = (frame_tick && time_left_q != 10'd0) ? time_left_q - 10'd1
                                                               : time_left_q;

    // Outputs are updated alongside the state so they appear one clock after
    // the deciding input, with no decode logic behind them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            q_idx_q     <= 4'd0;
            fb_cnt_q    <= '0;
            q_en_q      <= '0;
            bg_q        <= BG_IDLE;
            score_q     <= 4'd0;
            time_left_q <= 10'd0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_ASK;
                        q_idx_q     <= 4'd0;
                        score_q     <= 4'd0;
                        time_left_q <= LIMIT;
                        q_en_q      <= Q_FIRST;
                        bg_q        <= BG_ASK;
                        done_q      <= 1'b0;
                    end
                end

                ST_ASK: begin
                    time_left_q <= time_left_d;
                    // A submit on the final tick is still graded on its merits.
                    if (submit) begin
                        state_q  <= ST_FEEDBACK;
                        fb_cnt_q <= '0;
                        bg_q     <= answer_ok ? BG_OK : BG_BAD;
                        if (answer_ok && score_q != 4'hF) begin
                            score_q <= score_q + 4'd1;
                        end
                    end else if (frame_tick && time_left_q == 10'd1) begin
                        state_q  <= ST_FEEDBACK;
                        fb_cnt_q <= '0;
                        bg_q     <= BG_BAD;
                    end
                end

                ST_FEEDBACK: begin
                    if (frame_tick) begin
                        if (fb_cnt_q != FB_LAST) begin
                            fb_cnt_q <= fb_cnt_q + 1'b1;
                        end else if (q_idx_q == Q_LAST) begin
                            state_q <= ST_DONE;
                            q_en_q  <= '0;
                            bg_q    <= BG_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_ASK;
                            q_idx_q     <= q_idx_q + 4'd1;
                            time_left_q <= LIMIT;
                            q_en_q      <= q_en_q << 1;
                            bg_q        <= BG_ASK;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign q_en       = q_en_q;
    assign background = bg_q;
    assign score      = score_q;
    assign time_left  = time_left_q;
    assign done       = done_q;

    // The 4-bit score and question index only cover up to 15 questions.
    assert property (@(posedge clk) disable iff (!rst) (NUM_Q >= 1) && (NUM_Q <= 15))
        else $error("prompt_sequencer: NUM_Q must be 1..15");

endmodule

// File: tb/tb_prompt_sequencer.sv
// Directed bench for prompt_sequencer: grading, timeout, submit/timeout race,
// origin stall, full correct replay and asynchronous mid-question reset.
module tb_prompt_sequencer;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic [9:0]  hCount = 10'd1;
    logic [9:0]  vCount = 10'd1;
    logic        start  = 1'b0;
    logic        submit = 1'b0;
    logic [7:0]  answer = 8'h00;
    logic [3:0]  q_en;
    logic [11:0] background;
    logic [3:0]  score;
    logic [9:0]  time_left;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prompt_sequencer #(
        .NUM_Q        (4),
        .LIMIT_FRAMES (600),
        .FB_FRAMES    (30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hCount     (hCount),
        .vCount     (vCount),
        .start      (start),
        .submit     (submit),
        .answer     (answer),
        .q_en       (q_en),
        .background (background),
        .score      (score),
        .time_left  (time_left),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: counters at the origin for `hold` clocks; `sub` raises submit
    // during the clock in which frame_tick is high.
    task automatic frame(input int hold, input logic sub);
        hCount = 10'd0;
        vCount = 10'd0;
        @(negedge clk);
        submit = sub;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            submit = 1'b0;
        end
        hCount = 10'd1;
        vCount = 10'd1;
        @(negedge clk);
        submit = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_submit(input logic [7:0] ans);
        answer = ans;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
    endtask

    task automatic check_ask(input string tag, input logic [3:0] qe, input logic [9:0] tl,
                             input logic [3:0] sc);
        check({tag, ".q_en"}, 32'(q_en), 32'(qe));
        check({tag, ".bg"}, 32'(background), 32'h224);
        check({tag, ".time_left"}, 32'(time_left), 32'(tl));
        check({tag, ".score"}, 32'(score), 32'(sc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst.q_en", 32'(q_en), 32'h0);
        check("rst.bg", 32'(background), 32'h000);
        check("rst.score", 32'(score), 32'h0);
        check("rst.time_left", 32'(time_left), 32'h0);
        check("rst.done", 32'(done), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("idle.q_en", 32'(q_en), 32'h0);

        // Run 1: Q0 correct, Q1 wrong, Q2 timeout, Q3 submit on final tick.
        pulse_start();
        check_ask("start", 4'b0001, 10'd600, 4'd0);

        frame(4, 1'b0);
        check("stall.time_left", 32'(time_left), 32'd599);
        frame(1, 1'b0);
        check("tick.time_left", 32'(time_left), 32'd598);

        pulse_submit(8'b1101_0011);
        check("q0.bg", 32'(background), 32'h0F0);
        check("q0.score", 32'(score), 32'd1);
        check("q0.q_en", 32'(q_en), 32'b0001);
        pulse_submit(8'h00);
        check("fb_ignores_submit.score", 32'(score), 32'd1);
        check("fb_ignores_submit.bg", 32'(background), 32'h0F0);
        frames(29);
        check("fb29.bg", 32'(background), 32'h0F0);
        check("fb29.q_en", 32'(q_en), 32'b0001);
        frames(1);
        check_ask("q1", 4'b0010, 10'd600, 4'd1);

        pulse_submit(8'h00);
        check("q1.bg", 32'(background), 32'hF00);
        check("q1.score", 32'(score), 32'd1);
        frames(30);
        check_ask("q2", 4'b0100, 10'd600, 4'd1);

        frames(599);
        check_ask("q2.last", 4'b0100, 10'd1, 4'd1);
        frames(1);
        check("timeout.time_left", 32'(time_left), 32'd0);
        check("timeout.bg", 32'(background), 32'hF00);
        check("timeout.score", 32'(score), 32'd1);
        check("timeout.q_en", 32'(q_en), 32'b0100);
        frames(30);
        check_ask("q3", 4'b1000, 10'd600, 4'd1);

        frames(599);
        answer = 8'hFF;
        frame(1, 1'b1);
        check("race.bg", 32'(background), 32'h0F0);
        check("race.score", 32'(score), 32'd2);
        check("race.time_left", 32'(time_left), 32'd0);
        frames(30);
        check("done1.done", 32'(done), 32'd1);
        check("done1.q_en", 32'(q_en), 32'h0);
        check("done1.bg", 32'(background), 32'h00F);
        check("done1.score", 32'(score), 32'd2);
        pulse_submit(8'hFF);
        frames(2);
        check("done_hold.score", 32'(score), 32'd2);
        check("done_hold.done", 32'(done), 32'd1);

        // Run 2: every answer correct.
        pulse_start();
        check_ask("replay", 4'b0001, 10'd600, 4'd0);
        check("replay.done", 32'(done), 32'd0);
        pulse_submit(8'b1101_0011);
        frames(30);
        pulse_submit(8'h2A);
        frames(30);
        pulse_submit(8'h07);
        frames(30);
        check_ask("replay.q3", 4'b1000, 10'd600, 4'd3);
        pulse_submit(8'hFF);
        frames(30);
        check("done2.done", 32'(done), 32'd1);
        check("done2.q_en", 32'(q_en), 32'h0);
        check("done2.bg", 32'(background), 32'h00F);
        check("done2.score", 32'(score), 32'd4);

        // Run 3: asynchronous reset while question 1 is being asked.
        pulse_start();
        pulse_submit(8'b1101_0011);
        frames(30);
        check_ask("run3.q1", 4'b0010, 10'd600, 4'd1);
        #2 rst = 1'b0;
        #1;
        check("async.q_en", 32'(q_en), 32'h0);
        check("async.score", 32'(score), 32'h0);
        check("async.bg", 32'(background), 32'h000);
        check("async.time_left", 32'(time_left), 32'h0);
        check("async.done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst.q_en", 32'(q_en), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prompt_sequencer.md
Name: prompt_sequencer

Overview:
- Quiz-flow controller directly upstream of the per-question prompt controllers (q1_controller and its siblings).
- Drives their `en` and `background` inputs. Sequences through NUM_Q questions, checks the switch answer against a per-question constant, enforces a per-question frame-based time limit, flashes feedback colour, and keeps score.
- Frame timing is derived locally from the shared hCount/vCount raster counters.

Parameters:
- NUM_Q, 4, number of questions/prompt controllers enabled in order.
- LIMIT_FRAMES, 600, frames allowed per question (10 s at 60 Hz).
- FB_FRAMES, 30, frames the feedback colour is held.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- hCount  in  10  raster column from VGA timing generator
- vCount  in  10  raster row from VGA timing generator
- start  in  1  single-cycle pulse (debounced upstream) starting a quiz
- submit  in  1  single-cycle pulse (debounced upstream) submitting answer
- answer  in  8  switch value
- q_en  out  NUM_Q  one-hot prompt enable, bit i drives question i's `en`
- background  out  12  RGB444 background to all prompt controllers
- score  out  4  count of correct answers, saturating at 15
- time_left  out  10  frames remaining for current question
- done  out  1  high in DONE state

Behaviour:
- Reset values (async assert, sync-release recommended): state=IDLE, q_en=0, background=BG_IDLE, score=0, time_left=0, done=0, q_idx=0, fb_cnt=0, frame edge register=1.
- Frame tick:
  - `at_origin` = (hCount==0 && vCount==0), registered.
  - frame_tick = at_origin && !at_origin_d, one clk pulse per frame.
  - Must not repeat while the pixel enable holds the counters at 0 for several clk cycles.
- All outputs registered: a state change on cycle N is visible on outputs at N+1.
- States:
  - IDLE: q_en=0, background=BG_IDLE.
    - start -> ASK; q_idx=0, score=0, time_left=LIMIT_FRAMES.
  - ASK: q_en=1<<q_idx, background=BG_ASK.
    - Each frame_tick: time_left-1.
    - submit: correct = (answer==EXPECTED[q_idx]); if correct, score+1 (saturating). -> FEEDBACK with verdict latched.
    - frame_tick while time_left==1 and no submit that cycle: time_left=0, verdict=wrong, -> FEEDBACK.
    - submit and final frame_tick in the same cycle: submit wins and is graded normally.
    - start ignored.
  - FEEDBACK: q_en held at current question; background=BG_OK if correct else BG_BAD.
    - fb_cnt counts frame_ticks from 0. At fb_cnt==FB_FRAMES-1 on a tick: if q_idx==NUM_Q-1 -> DONE, else q_idx+1, time_left=LIMIT_FRAMES, -> ASK.
    - submit and start ignored.
  - DONE: q_en=0, background=BG_DONE, done=1, score held.
    - start -> ASK (same init as from IDLE).
- time_left never underflows below 0. score width 4; NUM_Q<=15 is enforced by assertion.
- Reset mid-question returns immediately to IDLE with all reset values.

Decomposition:
- Package quiz_pkg:
  - colour constants: BG_IDLE=12'h000, BG_ASK=12'h224, BG_OK=12'h0F0, BG_BAD=12'hF00, BG_DONE=12'h00F.
  - state encoding: IDLE/ASK/FEEDBACK/DONE, 2 bits.
  - expected-answer table: EXPECTED[0]=8'b11010011 (binary prompt), others 8'h2A, 8'h07, 8'hFF.
- Sub-module frame_tick_gen: origin detect plus edge register, outputs frame_tick. Reused by other frame-timed blocks.

Test Plan:
- Reset then start. Expect q_en=4'b0001 and background=12'h224 one cycle after start, time_left=600.
- In Q0, answer=8'b11010011 plus submit. Next cycle: background=12'h0F0, score=1. After 30 frame_ticks: q_en=4'b0010, background=12'h224, time_left=600.
- In Q1, answer=8'h00 plus submit. Expect background=12'hF00, score unchanged at 1.
- Timeout: no submit for 600 frames. Expect time_left reaching 0 and background=12'hF00. Submit pulse on the exact cycle of tick 600 with the correct answer: graded correct, score+1.
- Pixel-enable stall: hold hCount=vCount=0 for 4 clk cycles. Expect exactly one frame_tick (time_left decrements by 1).
- Complete all 4 questions correctly. Expect done=1, q_en=0, background=12'h00F, score=4. Then rst low mid-ASK on the replay: asynchronous return to IDLE, score=0, q_en=0 without waiting for clk.
